// File: rtl/store_buffer_if.sv
// Store-buffer bus: store request channel, load request channel, data-memory port and status.
// The pipeline side uses the master modport and the buffer uses the slave modport.
interface store_buffer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  st_valid;
    logic                  st_ready;
    logic [ADDR_WIDTH-1:0] st_addr;
    logic [DATA_WIDTH-1:0] st_data;
    logic [2:0]            st_funct3;
    logic                  st_err;

    logic                  ld_req;
    logic [ADDR_WIDTH-1:0] ld_addr;
    logic [2:0]            ld_funct3;
    logic                  ld_stall;

    logic                  mem_wr_en;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wr_data;
    logic [2:0]            mem_funct3;

    logic                  empty;
    logic                  full;

    modport master (
        output st_valid, st_addr, st_data, st_funct3,
        output ld_req, ld_addr, ld_funct3,
        input  st_ready, st_err, ld_stall,
        input  mem_wr_en, mem_addr, mem_wr_data, mem_funct3,
        input  empty, full
    );

    modport slave (
        input  st_valid, st_addr, st_data, st_funct3,
        input  ld_req, ld_addr, ld_funct3,
        output st_ready, st_err, ld_stall,
        output mem_wr_en, mem_addr, mem_wr_data, mem_funct3,
        output empty, full
    );
endinterface

// File: rtl/store_buffer.sv
// Posted-write FIFO draining SB/SH/SW into a shared data-memory port; loads to a pending word stall.
// Optional macro STORE_BUFFER_ALIGN_CHK_EN rejects misaligned SH/SW like an illegal funct3.
module store_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input logic           clk,
    input logic           rst_n,
    store_buffer_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [ADDR_WIDTH-1:0] entry_addr   [DEPTH];
    logic [DATA_WIDTH-1:0] entry_data   [DEPTH];
    logic [2:0]            entry_funct3 [DEPTH];

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;
    logic             err_q;

    logic             is_full;
    logic             accept;
    logic             legal;
    logic             push;
    logic             hit;
    logic             stall;
    logic             drain;
    logic [PTR_W-1:0] offset;

    assign is_full = (count == (PTR_W + 1)'(DEPTH));
    assign accept  = bus.st_valid && !is_full;
    assign push    = accept && legal;

    always_comb begin
        legal = (bus.st_funct3 == 3'b000) ||
                (bus.st_funct3 == 3'b001) ||
                (bus.st_funct3 == 3'b010);
`ifdef STORE_BUFFER_ALIGN_CHK_EN
        if (bus.st_funct3 == 3'b001 && bus.st_addr[0])
            legal = 1'b0;
        if (bus.st_funct3 == 3'b010 && bus.st_addr[1:0] != 2'b00)
            legal = 1'b0;
`endif
    end

    // Word-granular hazard check; an entry is live when its distance from rd_ptr is below count.
    always_comb begin
        hit    = 1'b0;
        offset = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset = PTR_W'(i) - rd_ptr;
            if ({1'b0, offset} < count &&
                entry_addr[i][ADDR_WIDTH-1:2] == bus.ld_addr[ADDR_WIDTH-1:2])
                hit = 1'b1;
        end
        if (push && bus.st_addr[ADDR_WIDTH-1:2] == bus.ld_addr[ADDR_WIDTH-1:2])
            hit = 1'b1;
    end

    // A stalled load gives up the port so the blocking store can drain.
    assign stall = bus.ld_req && hit;
    assign drain = (count != '0) && (!bus.ld_req || stall);

    assign bus.st_ready    = !is_full;
    assign bus.st_err      = err_q;
    assign bus.ld_stall    = stall;
    assign bus.empty       = (count == '0);
    assign bus.full        = is_full;
    assign bus.mem_wr_en   = drain;
    assign bus.mem_addr    = drain ? entry_addr[rd_ptr]   : bus.ld_addr;
    assign bus.mem_funct3  = drain ? entry_funct3[rd_ptr] : bus.ld_funct3;
    assign bus.mem_wr_data = drain ? entry_data[rd_ptr]   : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            err_q  <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (drain)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, drain})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            err_q <= accept && !legal;
        end
    end

    // Entry payload carries no reset; liveness is tracked purely by pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            entry_addr[wr_ptr]   <= bus.st_addr;
            entry_data[wr_ptr]   <= bus.st_data;
            entry_funct3[wr_ptr] <= bus.st_funct3;
        end
    end

    a_count_range : assert property (@(posedge clk) disable iff (!rst_n)
        count <= (PTR_W + 1)'(DEPTH));
    a_no_push_full : assert property (@(posedge clk) disable iff (!rst_n)
        is_full |-> !push);
    a_drain_nonempty : assert property (@(posedge clk) disable iff (!rst_n)
        drain |-> (count != '0));
endmodule

// File: tb/tb_store_buffer.sv
// Scoreboarded bench for store_buffer: directed scenarios followed by randomized traffic
// compared against a queue-based reference model of pending stores.
module tb_store_buffer;
    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  f3;
    } ent_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    bit   err_exp;
    ent_t mq[$];
    ent_t sb_q[$];

    store_buffer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    store_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit legal(input logic [2:0] f, input logic [31:0] a);
        if (f > 3'd2) return 1'b0;
`ifdef STORE_BUFFER_ALIGN_CHK_EN
        if (f == 3'd1 && a[0]) return 1'b0;
        if (f == 3'd2 && a[1:0] != 2'b00) return 1'b0;
`endif
        return 1'b1;
    endfunction

    // Writes leave the buffer in the order they were accepted.
    always @(negedge clk) begin : monitor
        ent_t e;
        if (rst_n === 1'b1 && bus.mem_wr_en === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL stray_write: got write to %h expected none", bus.mem_addr);
            end else begin
                e = sb_q.pop_front();
                chk("wr_addr",   bus.mem_addr,          e.addr);
                chk("wr_data",   bus.mem_wr_data,       e.data);
                chk("wr_funct3", 32'(bus.mem_funct3),   32'(e.f3));
            end
        end
    end

    task automatic step(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                        input logic [2:0] sf, input logic lr, input logic [31:0] la,
                        input logic [2:0] lf);
        bit   full_e, push_e, hit_e, stall_e, drain_e;
        ent_t e;
        bus.st_valid  = sv;
        bus.st_addr   = sa;
        bus.st_data   = sd;
        bus.st_funct3 = sf;
        bus.ld_req    = lr;
        bus.ld_addr   = la;
        bus.ld_funct3 = lf;
        @(negedge clk);
        full_e = (mq.size() == DEPTH);
        push_e = sv && !full_e && legal(sf, sa);
        hit_e  = 1'b0;
        foreach (mq[i]) if (mq[i].addr[31:2] == la[31:2]) hit_e = 1'b1;
        if (push_e && sa[31:2] == la[31:2]) hit_e = 1'b1;
        stall_e = lr && hit_e;
        drain_e = (mq.size() != 0) && (!lr || stall_e);
        chk("empty",     32'(bus.empty),     32'(mq.size() == 0));
        chk("full",      32'(bus.full),      32'(full_e));
        chk("st_ready",  32'(bus.st_ready),  32'(!full_e));
        chk("st_err",    32'(bus.st_err),    32'(err_exp));
        chk("ld_stall",  32'(bus.ld_stall),  32'(stall_e));
        chk("mem_wr_en", 32'(bus.mem_wr_en), 32'(drain_e));
        if (!drain_e) begin
            chk("mem_addr",    bus.mem_addr,        la);
            chk("mem_funct3",  32'(bus.mem_funct3), 32'(lf));
            chk("mem_wr_data", bus.mem_wr_data,     32'h0);
        end
        if (push_e) begin
            e.addr = sa;
            e.data = sd;
            e.f3   = sf;
            mq.push_back(e);
            sb_q.push_back(e);
        end
        @(posedge clk);
        if (drain_e) void'(mq.pop_front());
        err_exp = sv && !full_e && !legal(sf, sa);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0, 3'd2, 1'b0, 32'h40, 3'd2);
    endtask

    task automatic reset_mid();
        bus.st_valid = 1'b0;
        bus.ld_req   = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_empty",     32'(bus.empty),     32'd1);
        chk("rst_mem_wr_en", 32'(bus.mem_wr_en), 32'd0);
        chk("rst_st_ready",  32'(bus.st_ready),  32'd1);
        chk("rst_full",      32'(bus.full),      32'd0);
        chk("rst_ld_stall",  32'(bus.ld_stall),  32'd0);
        mq.delete();
        sb_q.delete();
        err_exp = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        err_exp  = 1'b0;
        rst_n    = 1'b0;
        bus.st_valid = 1'b0; bus.st_addr = '0; bus.st_data = '0; bus.st_funct3 = 3'd2;
        bus.ld_req = 1'b0; bus.ld_addr = 32'h40; bus.ld_funct3 = 3'd2;
        #12;
        chk("init_empty",     32'(bus.empty),     32'd1);
        chk("init_st_ready",  32'(bus.st_ready),  32'd1);
        chk("init_mem_wr_en", 32'(bus.mem_wr_en), 32'd0);
        chk("init_st_err",    32'(bus.st_err),    32'd0);
        chk("init_mem_addr",  bus.mem_addr,       32'h40);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle(2);

        // Single SW drains the cycle after acceptance.
        step(1'b1, 32'h10, 32'hDEADBEEF, 3'd2, 1'b0, 32'h40, 3'd2);
        idle(3);

        // Fill while a non-conflicting load owns the port, then release.
        for (int i = 0; i < 4; i++)
            step(1'b1, 32'(i * 4), 32'hA000_0000 + 32'(i), 3'd2, 1'b1, 32'h80, 3'd2);
        step(1'b1, 32'h50, 32'h5555_5555, 3'd2, 1'b1, 32'h80, 3'd2);
        idle(6);

        // Byte store followed by a load to the same word.
        step(1'b1, 32'h21, 32'h0000_00AB, 3'd0, 1'b1, 32'h80, 3'd0);
        step(1'b0, 32'h0, 32'h0, 3'd0, 1'b1, 32'h22, 3'd4);
        step(1'b0, 32'h0, 32'h0, 3'd0, 1'b1, 32'h22, 3'd4);
        idle(2);

        // Illegal funct3 handshakes but is not enqueued.
        step(1'b1, 32'h30, 32'h1234_5678, 3'd3, 1'b0, 32'h40, 3'd2);
        idle(3);

        // Reset with three stores pending.
        for (int i = 0; i < 3; i++)
            step(1'b1, 32'h100 + 32'(i * 4), 32'hC0DE_0000 + 32'(i), 3'd2, 1'b1, 32'h80, 3'd2);
        reset_mid();
        idle(4);

        // Misaligned SW: enqueued normally, rejected with alignment checking.
        step(1'b1, 32'h06, 32'h0BAD_F00D, 3'd2, 1'b0, 32'h40, 3'd2);
        idle(3);

        for (int n = 0; n < 2000; n++) begin
            logic        sv, lr;
            logic [31:0] sa, sd, la;
            logic [2:0]  sf, lf;
            sv = ($urandom_range(0, 1) == 1);
            sa = 32'($urandom_range(0, 63));
            sd = $urandom;
            sf = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            lr = ($urandom_range(0, 9) < 5);
            la = 32'($urandom_range(0, 63));
            lf = 3'($urandom_range(0, 5));
            step(sv, sa, sd, sf, lr, la, lf);
        end
        idle(DEPTH + 4);
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write buffer between the execute/memory pipeline stage and the data memory.
- Queues SB/SH/SW requests in a FIFO and drains them into the data memory's single shared address port when no load owns the port.
- Stalls any load that hits a word with a pending store, giving in-order memory semantics without byte forwarding.
- Drives the data memory's write-enable, address, data and funct3 inputs; the load result comes directly from the data memory.

Parameters:
- DATA_WIDTH, 32, store data width.
- ADDR_WIDTH, 32, byte address width.
- DEPTH, 4, FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- st_valid  input  1  store request valid.
- st_ready  output  1  buffer can accept a store this cycle.
- st_addr  input  ADDR_WIDTH  store byte address.
- st_data  input  DATA_WIDTH  store data, right-aligned.
- st_funct3  input  3  000 SB, 001 SH, 010 SW.
- st_err  output  1  registered one-cycle pulse: a store was rejected.
- ld_req  input  1  load wants the memory port this cycle.
- ld_addr  input  ADDR_WIDTH  load byte address.
- ld_funct3  input  3  load type, passed to memory.
- ld_stall  output  1  load must hold; a pending store targets the same word.
- mem_wr_en  output  1  write strobe to data memory.
- mem_addr  output  ADDR_WIDTH  shared memory address.
- mem_wr_data  output  DATA_WIDTH  write data to memory.
- mem_funct3  output  3  access type to memory.
- empty  output  1  no pending stores; used by fence/halt logic.
- full  output  1  count == DEPTH.

Behaviour:
- Storage: DEPTH entries of {addr, data, funct3}; rd_ptr and wr_ptr of log2(DEPTH) bits, wrapping modulo DEPTH; count of log2(DEPTH)+1 bits.
- Reset (rst_n low, asynchronous):
  - count=0, pointers=0, st_err=0.
  - Outputs: empty=1, full=0, st_ready=1, mem_wr_en=0, ld_stall=0.
  - Entry contents are don't-care.
  - Reset mid-operation discards all pending stores; no partial drain completes.
- st_ready = !full (combinational). A push into a full buffer is never allowed, even if a drain occurs in the same cycle.
- Push: st_valid && st_ready at a rising edge.
  - st_funct3 in {000,001,010}: write the entry at wr_ptr and increment wr_ptr.
  - Any other st_funct3: handshake completes, nothing is enqueued, st_err=1 for the following cycle.
- drain = (count != 0) && (!ld_req || ld_stall), combinational.
  - A stalled load yields the port so the buffer progresses; no deadlock.
- Memory port mux (combinational):
  - mem_wr_en = drain.
  - mem_addr / mem_funct3 = head entry when drain, else ld_addr / ld_funct3.
  - mem_wr_data = head data when drain, else 0.
- Pop: rd_ptr increments at the edge where drain=1. The data memory commits the write at that same edge.
- Latency: a store accepted at edge N appears on mem_wr_en no earlier than the cycle after N. Minimum accept-to-commit is 1 cycle with ld_req low.
- Simultaneous valid push and pop: count unchanged; both pointers advance.
- ld_stall = ld_req && (match against any valid entry || match against the store being accepted this cycle).
  - A match compares addr[ADDR_WIDTH-1:2] only, i.e. word granularity.
  - Conservative: a byte store to a different byte of the same word still stalls the load.
- empty = (count==0); full = (count==DEPTH); both combinational from count.
- Order: stores drain strictly FIFO; no merging, no reordering.

Optional Feature:
- Macro: STORE_BUFFER_ALIGN_CHK_EN.
- Defined:
  - SH with st_addr[0]=1, or SW with st_addr[1:0]!=00, is rejected as for an illegal funct3.
  - Handshake completes, nothing is enqueued, st_err pulses.
- Undefined: alignment is not checked; misaligned stores are enqueued unchanged.

Test Plan:
- Reset then idle -> empty=1, st_ready=1, mem_wr_en=0, mem_addr follows ld_addr (0x40 in -> 0x40 out).
- SW 0xDEADBEEF @0x10, ld_req=0 -> next cycle mem_wr_en=1, mem_addr=0x10, mem_wr_data=0xDEADBEEF, mem_funct3=010; empty=1 afterwards.
- Hold ld_req=1 to 0x80 while issuing 4 SWs to 0x00,0x04,0x08,0x0C -> full=1, st_ready=0, mem_wr_en=0. Release ld_req -> 4 writes drain in order on 4 consecutive cycles; count wraps the pointers correctly.
- SB 0xAB @0x21 pending, load @0x22 -> ld_stall=1, port given to drain; the next cycle ld_stall=0 and mem_addr=0x22.
- Store with st_funct3=011 -> st_ready handshake completes, st_err=1 for exactly one cycle, count unchanged.
- Pulse rst_n low with 3 entries pending -> immediately empty=1 and mem_wr_en=0; no stale write after release. With STORE_BUFFER_ALIGN_CHK_EN, SW @0x06 -> st_err=1 and no enqueue.
